key_press_decoder: RTL and testbench
====================================

// Module: key_press_decoder
// PURPOSE
// - Consumes the debounced key events (key_flag/key_state) of the key debounce stage; classifies each
//   gesture as single click, double click, or long press, plus auto-repeat while held after long press.
// - Sits between the debouncer and application logic (LED/counter/menu control); one instance per key.
// - Outputs are 1-cycle pulses in the clk domain; the debounce filter is not duplicated here.
// PARAMETERS
// - LONG_CYC    50_000_000  press cycles (1 s at 50 MHz) before long_press fires
// - DBL_CYC     15_000_000  max gap cycles (300 ms) after first release for a second press to count as double
// - REPEAT_CYC  10_000_000  hold_repeat period (200 ms) after long_press; 0 disables repeat
// - CNT_W       26          timer width; must satisfy 2**CNT_W > max(LONG_CYC, DBL_CYC, REPEAT_CYC)
// PORTS
// - clk          in   1      system clock, 50 MHz
// - rst          in   1      async active-low reset
// - key_flag     in   1      1-cycle pulse on each debounced edge
// - key_state    in   1      debounced level, 1 = pressed; sampled when key_flag=1
// - click        out  1      pulse: single click detected
// - dbl_click    out  1      pulse: double click detected
// - long_press   out  1      pulse: press held LONG_CYC cycles
// - hold_repeat  out  1      pulse every REPEAT_CYC cycles while still held after long_press
// - busy         out  1      1 whenever state != IDLE
// BEHAVIOUR
// - press = key_flag & key_state; release = key_flag & ~key_state.
// - Reset (async, rst=0): state=IDLE, timer=0, all outputs 0. Reset mid-gesture discards it, no pulse.
// - Single timer cnt[CNT_W-1:0]: cleared on every state change, else +1; never wraps (terminal counts
//   always force a transition or a clear before overflow).
// - All outputs registered: pulse asserts the cycle after the triggering input/terminal count, 1 cycle wide.
// - States (one-hot, 5): IDLE, PRESS1, WAIT2, PRESS2, HELD.
//   IDLE:   press -> PRESS1. release ignored.
//   PRESS1: release -> WAIT2. cnt==LONG_CYC-1 (no release) -> long_press, HELD.
//           release and terminal in same cycle: release wins (-> WAIT2, no long_press).
//   WAIT2:  press -> PRESS2. cnt==DBL_CYC-1 (no press) -> click, IDLE.
//           press and terminal in same cycle: press wins (-> PRESS2, no click).
//   PRESS2: release -> dbl_click, IDLE. cnt==LONG_CYC-1 -> long_press, HELD (first click discarded,
//           no click/dbl_click). Same-cycle tie: release wins.
//   HELD:   cnt==REPEAT_CYC-1 -> hold_repeat, cnt cleared, stay. release -> IDLE, no further pulse.
//           release and repeat terminal same cycle: release wins, no hold_repeat.
// - Protocol violations (press while pressed, release while released) are ignored; state unchanged.
// - At most one of click/dbl_click/long_press/hold_repeat high in any cycle.
// - busy registered with state (0 in IDLE, 1 otherwise); goes 0 the same cycle click/dbl_click asserts.
// STRUCTURE
// - key_pkg: state one-hot localparams (KP_IDLE..KP_HELD), default timing constants for 50 MHz.
// - Sub-module kp_timer: CNT_W counter with sync clear and enable; compare logic stays in the parent.
// - Parent: next-state logic, terminal compares, registered pulse outputs. No other hierarchy.
// TESTING (bench parameters LONG_CYC=100, DBL_CYC=30, REPEAT_CYC=20; key_flag driven as 1-cycle pulses)
// - Press, release 10 cycles later, idle 40 -> exactly one click, 30 cycles after release (+1); busy then 0.
// - Press 10, release, press 10 cycles later, release after 10 -> one dbl_click the cycle after 2nd release,
//   no click.
// - Press held 165 cycles -> long_press at cycle 100(+1), hold_repeat at +20 and +40 and +60; release -> IDLE.
// - Ties: release on the PRESS1 terminal cycle -> no long_press, WAIT2; press on the WAIT2 terminal cycle
//   -> no click, PRESS2.
// - rst=0 asserted mid-PRESS2 and mid-HELD -> outputs 0 and IDLE asynchronously; no stray pulse after release.
// - Redundant presses/releases (protocol violations) in each state -> no state change, no pulse;
//   REPEAT_CYC=0 -> no hold_repeat.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants for the key press decoder: one-hot state encoding and 50 MHz default timings.
package key_pkg;

    localparam int unsigned KP_N_STATES = 5;

    // Bit positions of the one-hot state vector
    localparam int unsigned KP_IDLE   = 0;
    localparam int unsigned KP_PRESS1 = 1;
    localparam int unsigned KP_WAIT2  = 2;
    localparam int unsigned KP_PRESS2 = 3;
    localparam int unsigned KP_HELD   = 4;

    typedef logic [KP_N_STATES-1:0] kp_state_t;

    localparam kp_state_t ST_IDLE   = 5'b00001;
    localparam kp_state_t ST_PRESS1 = 5'b00010;
    localparam kp_state_t ST_WAIT2  = 5'b00100;
    localparam kp_state_t ST_PRESS2 = 5'b01000;
    localparam kp_state_t ST_HELD   = 5'b10000;

    localparam int unsigned KP_LONG_CYC_DEF   = 50_000_000;
    localparam int unsigned KP_DBL_CYC_DEF    = 15_000_000;
    localparam int unsigned KP_REPEAT_CYC_DEF = 10_000_000;
    localparam int unsigned KP_CNT_W_DEF      = 26;

    typedef struct packed {
        logic click;
        logic dbl_click;
        logic long_press;
        logic hold_repeat;
    } kp_pulse_t;

endpackage

// File: rtl/key_press_decoder_if.sv
// Debounced key events in, gesture pulses and busy flag out.
interface key_press_decoder_if;

    logic key_flag;
    logic key_state;
    logic click;
    logic dbl_click;
    logic long_press;
    logic hold_repeat;
    logic busy;

    modport master (
        output key_flag,
        output key_state,
        input  click,
        input  dbl_click,
        input  long_press,
        input  hold_repeat,
        input  busy
    );

    modport slave (
        input  key_flag,
        input  key_state,
        output click,
        output dbl_click,
        output long_press,
        output hold_repeat,
        output busy
    );

endinterface

// File: rtl/kp_timer.sv
// Free-running gesture timer with synchronous clear (priority) and count enable.
module kp_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/key_press_decoder.sv
// Classifies debounced key gestures into click, double click, long press and auto-repeat pulses.
module key_press_decoder
    import key_pkg::*;
#(
    parameter int unsigned LONG_CYC   = KP_LONG_CYC_DEF,
    parameter int unsigned DBL_CYC    = KP_DBL_CYC_DEF,
    parameter int unsigned REPEAT_CYC = KP_REPEAT_CYC_DEF,
    parameter int unsigned CNT_W      = KP_CNT_W_DEF
) (
    input logic                clk,
    input logic                rst,
    key_press_decoder_if.slave kp
);

    localparam bit               REPEAT_EN   = (REPEAT_CYC != 0);
    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_TERM    = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_EN ? REPEAT_CYC - 1 : 0);

    kp_state_t        state_q, state_d;
    kp_pulse_t        pulse_q, pulse_d;
    logic             busy_q;
    logic [CNT_W-1:0] cnt;
    logic             prs_ev, rel_ev;
    logic             long_hit, dbl_hit, rep_hit;
    logic             tmr_clr, tmr_en;

    assign prs_ev   = kp.key_flag & kp.key_state;
    assign rel_ev   = kp.key_flag & ~kp.key_state;
    assign long_hit = (cnt == LONG_TERM);
    assign dbl_hit  = (cnt == DBL_TERM);
    assign rep_hit  = REPEAT_EN && (cnt == REPEAT_TERM);

    // Release/press always beats a terminal count landing in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[KP_IDLE]: begin
                if (prs_ev) state_d = ST_PRESS1;
            end
            state_q[KP_PRESS1]: begin
                if (rel_ev)        state_d = ST_WAIT2;
                else if (long_hit) state_d = ST_HELD;
            end
            state_q[KP_WAIT2]: begin
                if (prs_ev)       state_d = ST_PRESS2;
                else if (dbl_hit) state_d = ST_IDLE;
            end
            state_q[KP_PRESS2]: begin
                if (rel_ev)        state_d = ST_IDLE;
                else if (long_hit) state_d = ST_HELD;
            end
            state_q[KP_HELD]: begin
                if (rel_ev) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pulse_d = '0;
        unique case (1'b1)
            state_q[KP_PRESS1]: pulse_d.long_press = !rel_ev && long_hit;
            state_q[KP_WAIT2]:  pulse_d.click      = !prs_ev && dbl_hit;
            state_q[KP_PRESS2]: begin
                pulse_d.dbl_click  = rel_ev;
                pulse_d.long_press = !rel_ev && long_hit;
            end
            state_q[KP_HELD]:   pulse_d.hold_repeat = !rel_ev && rep_hit;
            default:            pulse_d = '0;
        endcase
    end

    // Idle and repeat-disabled HELD have no terminal count, so the timer is parked there
    assign tmr_clr = (state_d != state_q) | pulse_d.hold_repeat;
    assign tmr_en  = !state_q[KP_IDLE] && !(state_q[KP_HELD] && !REPEAT_EN);

    kp_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .cnt (cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pulse_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            busy_q  <= !state_d[KP_IDLE];
        end
    end

    assign kp.click       = pulse_q.click;
    assign kp.dbl_click   = pulse_q.dbl_click;
    assign kp.long_press  = pulse_q.long_press;
    assign kp.hold_repeat = pulse_q.hold_repeat;
    assign kp.busy        = busy_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Scoreboard bench: a timestamp-based gesture model predicts pulses for a repeating and a
// repeat-disabled decoder fed the same key events; a monitor pops and compares each pulse.
module tb_key_press_decoder;

    localparam int unsigned LONG = 100;
    localparam int unsigned DBL  = 30;
    localparam int unsigned REP  = 20;
    localparam int unsigned CW   = 8;

    localparam int PL_CLICK = 1;
    localparam int PL_DBL   = 2;
    localparam int PL_LONG  = 3;
    localparam int PL_REP   = 4;

    typedef struct packed {
        int     ph;
        longint st;
        int     pl;
    } mres_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   key_flag = 1'b0;
    logic   key_state = 1'b0;
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;

    int     ph0 = 0, ph1 = 0;
    longint st0 = 0, st1 = 0;
    longint q0[$];
    longint q1[$];
    mres_t  r0, r1;

    key_press_decoder_if bus0();
    key_press_decoder_if bus1();

    assign bus0.key_flag  = key_flag;
    assign bus0.key_state = key_state;
    assign bus1.key_flag  = key_flag;
    assign bus1.key_state = key_state;

    key_press_decoder #(
        .LONG_CYC   (LONG),
        .DBL_CYC    (DBL),
        .REPEAT_CYC (REP),
        .CNT_W      (CW)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .kp  (bus0)
    );

    key_press_decoder #(
        .LONG_CYC   (LONG),
        .DBL_CYC    (DBL),
        .REPEAT_CYC (0),
        .CNT_W      (CW)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .kp  (bus1)
    );

    always #5 clk = ~clk;

    // Gesture phases: 0 idle, 1 first press, 2 gap, 3 second press, 4 held after long press.
    // st is the edge at which the current timing interval began.
    function automatic mres_t step(input int ph, input longint st, input longint t,
                                   input int unsigned rep, input bit pr, input bit rl);
        mres_t r;
        r.ph = ph;
        r.st = st;
        r.pl = 0;
        case (ph)
            0: if (pr) begin r.ph = 1; r.st = t; end
            1: if (rl) begin r.ph = 2; r.st = t; end
               else if (t - st == LONG) begin r.pl = PL_LONG; r.ph = 4; r.st = t; end
            2: if (pr) begin r.ph = 3; r.st = t; end
               else if (t - st == DBL) begin r.pl = PL_CLICK; r.ph = 0; end
            3: if (rl) begin r.pl = PL_DBL; r.ph = 0; end
               else if (t - st == LONG) begin r.pl = PL_LONG; r.ph = 4; r.st = t; end
            4: if (rl) r.ph = 0;
               else if (rep != 0 && t - st == rep) begin r.pl = PL_REP; r.st = t; end
            default: r.ph = 0;
        endcase
        return r;
    endfunction

    always_comb r0 = step(ph0, st0, cyc, REP, key_flag & key_state, key_flag & ~key_state);
    always_comb r1 = step(ph1, st1, cyc, 0, key_flag & key_state, key_flag & ~key_state);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph0 <= 0;
            ph1 <= 0;
        end else begin
            ph0 <= r0.ph;
            st0 <= r0.st;
            ph1 <= r1.ph;
            st1 <= r1.st;
            if (r0.pl != 0) q0.push_back(cyc * 8 + longint'(r0.pl));
            if (r1.pl != 0) q1.push_back(cyc * 8 + longint'(r1.pl));
        end
    end

    function automatic int qsz(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    function automatic longint qfront(input int idx);
        return (idx == 0) ? q0[0] : q1[0];
    endfunction

    function automatic longint qpop(input int idx);
        return (idx == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic chk(input int idx, input logic [3:0] pv, input logic bsy, input int exp_ph);
        longint e;
        longint x;
        int     typ;
        e = cyc - 1;
        while (qsz(idx) > 0 && (qfront(idx) >>> 3) < e) begin
            x = qpop(idx);
            n_cmp++;
            n_fail++;
            $display("FAIL missed_pulse dut%0d: got nothing at edge %0d, required type %0d",
                     idx, x >>> 3, x & 7);
        end
        if (pv != 4'b0000) begin
            typ = pv[0] ? PL_CLICK : pv[1] ? PL_DBL : pv[2] ? PL_LONG : PL_REP;
            n_cmp++;
            if ($countones(pv) > 1) begin
                n_fail++;
                $display("FAIL multi_pulse dut%0d edge %0d: got %b, required one-hot", idx, e, pv);
            end else if (qsz(idx) == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse dut%0d edge %0d: got type %0d, required none",
                         idx, e, typ);
            end else begin
                x = qpop(idx);
                if ((x >>> 3) != e || int'(x & 7) != typ) begin
                    n_fail++;
                    $display("FAIL pulse dut%0d: got type %0d at edge %0d, required type %0d at %0d",
                             idx, typ, e, x & 7, x >>> 3);
                end
            end
        end
        n_cmp++;
        if (bsy !== (exp_ph != 0)) begin
            n_fail++;
            $display("FAIL busy dut%0d edge %0d: got %b, required %b", idx, e, bsy, exp_ph != 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk(0, {bus0.hold_repeat, bus0.long_press, bus0.dbl_click, bus0.click}, bus0.busy, ph0);
            chk(1, {bus1.hold_repeat, bus1.long_press, bus1.dbl_click, bus1.click}, bus1.busy, ph1);
        end
    end

    // All stimulus tasks start and end on a falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ev(input logic st);
        key_flag  = 1'b1;
        key_state = st;
        @(negedge clk);
        key_flag  = 1'b0;
    endtask

    // Release lands d rising edges after the press
    task automatic hold(input int d);
        ev(1'b1);
        idle(d - 1);
        ev(1'b0);
    endtask

    // Next event lands g rising edges after the previous one
    task automatic gap(input int g);
        idle(g - 1);
    endtask

    task automatic async_reset(input string tag);
        logic [9:0] outs;
        #2 rst = 1'b0;
        #1;
        outs = {bus0.click, bus0.dbl_click, bus0.long_press, bus0.hold_repeat, bus0.busy,
                bus1.click, bus1.dbl_click, bus1.long_press, bus1.hold_repeat, bus1.busy};
        n_cmp++;
        if (outs != 10'b0) begin
            n_fail++;
            $display("FAIL reset_%s: got outputs %b, required all zero", tag, outs);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic int pick_hold();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(1, 20));
            1:       return int'($urandom_range(LONG - 2, LONG + 2));
            2:       return int'(LONG + REP * $urandom_range(1, 3)) + int'($urandom_range(0, 2)) - 1;
            default: return int'($urandom_range(21, 90));
        endcase
    endfunction

    function automatic int pick_gap();
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(1, 25));
            1:       return int'($urandom_range(DBL - 1, DBL + 1));
            default: return int'($urandom_range(35, 60));
        endcase
    endfunction

    initial begin
        idle(3);
        rst = 1'b1;
        idle(2);

        hold(10); idle(45);                       // single click
        hold(10); gap(10); hold(10); idle(45);    // double click
        hold(165); idle(40);                      // long press with repeats
        hold(LONG); gap(DBL); hold(10); idle(45); // both tie cases

        // Redundant events in every state
        ev(1'b0); idle(5);
        ev(1'b1); idle(3); ev(1'b1); idle(3);
        ev(1'b0); idle(3); ev(1'b0); idle(3);
        ev(1'b1); ev(1'b1); idle(3); ev(1'b0); idle(40);
        ev(1'b1); idle(110); ev(1'b1); idle(5); ev(1'b0); idle(40);

        // Reset mid-PRESS2 and mid-HELD, then a stale release
        hold(10); gap(10); ev(1'b1); idle(5);
        async_reset("press2"); idle(3); ev(1'b0); idle(40);
        ev(1'b1); idle(120);
        async_reset("held"); idle(3); ev(1'b0); idle(40);

        for (int i = 0; i < 40; i++) begin
            hold(pick_hold());
            if ($urandom_range(0, 4) == 0) ev(logic'($urandom_range(0, 1)));
            gap(pick_gap());
        end
        ev(1'b0);
        idle(150);

        while (q0.size() > 0 || q1.size() > 0) begin
            n_cmp++;
            n_fail++;
            if (q0.size() > 0) begin
                $display("FAIL pending_pulse dut0: got nothing, required type %0d at edge %0d",
                         q0[0] & 7, q0[0] >>> 3);
                void'(q0.pop_front());
            end else begin
                $display("FAIL pending_pulse dut1: got nothing, required type %0d at edge %0d",
                         q1[0] & 7, q1[0] >>> 3);
                void'(q1.pop_front());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
